prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/prog_loader.sv | 117 +++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding and
// default geometry of the instruction ROM.
package prog_loader_pkg;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_MAX_WORDS = 4096;
  localparam int HDR_BYTES     = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/prog_loader.sv
// Receives a length-prefixed big-endian byte stream and writes it word by word
// into the instruction ROM, holding the CPU in reset until a load completes.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   IDLE      | no load since reset, CPU held in reset
//   HDR_HI    | waiting for length byte N[15:8]
//   HDR_LO    | waiting for length byte N[7:0], then range-check N
//   DATA_HI   | waiting for high byte of the current word
//   DATA_LO   | waiting for low byte of the current word
//   WRITE     | one-cycle ROM write of the assembled word
//   DONE      | load complete, CPU released
//   ERROR     | header rejected (N too large), CPU held in reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_din,
  output logic              rom_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  state_e              state_q, state_d;
  logic [7:0]          hi_q;
  logic [15:0]         index_q;
  logic [15:0]         word_count_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [15:0]         rom_din_q;
  logic                rom_we_q;
  logic                cpu_rst_q;

  logic                xfer;
  logic [15:0]         rx_word;
  logic                last_word;

  assign in_ready  = (state_q == S_HDR_HI)  || (state_q == S_HDR_LO) ||
                     (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
  assign busy      = in_ready || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);

  assign xfer      = in_valid && in_ready;
  assign rx_word   = {hi_q, in_data};
  assign last_word = (index_q == (word_count_q - 16'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_HDR_HI;
      S_HDR_HI:  if (xfer) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (xfer) begin
          if (rx_word == 16'd0)                 state_d = S_DONE;
          else if (int'(rx_word) > MAX_WORDS)   state_d = S_ERROR;
          else                                  state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (xfer) state_d = S_DATA_LO;
      S_DATA_LO: if (xfer) state_d = S_WRITE;
      S_WRITE:   state_d = last_word ? S_DONE : S_DATA_HI;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hi_q         <= 8'd0;
      index_q      <= 16'd0;
      word_count_q <= 16'd0;
      rom_addr_q   <= '0;
      rom_din_q    <= 16'd0;
      rom_we_q     <= 1'b0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= (state_d != S_DONE);
      rom_we_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (start) index_q <= 16'd0;
        S_HDR_HI, S_DATA_HI:     if (xfer) hi_q <= in_data;
        S_HDR_LO:                if (xfer) word_count_q <= rx_word;
        // Write strobe, address and data are staged here so they are
        // registered and valid for exactly the WRITE cycle.
        S_DATA_LO: begin
          if (xfer) begin
            rom_we_q   <= 1'b1;
            rom_addr_q <= index_q[ADDR_W-1:0];
            rom_din_q  <= rx_word;
          end
        end
        S_WRITE:  if (!last_word) index_q <= index_q + 16'd1;
        default:  ;
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_din    = rom_din_q;
  assign rom_we     = rom_we_q;
  assign cpu_rst    = cpu_rst_q;
  assign word_count = word_count_q;

endmodule
